// File: rtl/nanoprocessor_pkg.sv
// rtl/nanoprocessor_pkg.sv - opcodes, ALU codes, FSM encoding and instruction field layout
package nanoprocessor_pkg;

  localparam int INSTR_W   = 12;
  localparam int OPC_LSB   = 9;
  localparam int OPC_W     = 3;
  localparam int RA_LSB    = 6;
  localparam int RB_LSB    = 3;
  localparam int REG_SEL_W = 3;
  localparam int IMM_LSB   = 0;
  localparam int IMM_W     = 4;
  localparam int TGT_LSB   = 0;
  localparam int TGT_W     = 3;

  typedef logic [OPC_W-1:0] opcode_t;
  typedef logic [1:0]       alu_code_t;

  localparam opcode_t OP_ADD  = 3'b000;
  localparam opcode_t OP_SUB  = 3'b001;
  localparam opcode_t OP_AND  = 3'b010;
  localparam opcode_t OP_MOVI = 3'b011;
  localparam opcode_t OP_JZR  = 3'b100;
  localparam opcode_t OP_HALT = 3'b101;

  localparam alu_code_t ALU_ADD = 2'b00;
  localparam alu_code_t ALU_SUB = 2'b01;
  localparam alu_code_t ALU_AND = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FETCH   = 2'b01,
    ST_EXECUTE = 2'b10,
    ST_HALT    = 2'b11
  } state_t;

  function automatic logic is_alu_op(input opcode_t opc);
    return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND);
  endfunction

  function automatic alu_code_t alu_code_of(input opcode_t opc);
    alu_code_t code;
    case (opc)
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/register_bank.sv
// rtl/register_bank.sv - eight-entry register file, two read ports, one write port, R0 hardwired to zero
module register_bank
  import nanoprocessor_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [REG_SEL_W-1:0] rd_a_sel,
  output logic [N-1:0]         rd_a_data,
  input  logic [REG_SEL_W-1:0] rd_b_sel,
  output logic [N-1:0]         rd_b_data,
  input  logic                 wr_en,
  input  logic [REG_SEL_W-1:0] wr_sel,
  input  logic [N-1:0]         wr_data,
  output logic [N-1:0]         r7
);

  logic [N-1:0] regs_q [8];
  logic [N-1:0] regs_d [8];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_sel] = wr_data;
    end
    // R0 is never stored, so a write to it simply vanishes
    regs_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_a_data = regs_q[rd_a_sel];
  assign rd_b_data = regs_q[rd_b_sel];
  assign r7        = regs_q[7];

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/execute sequencer for a tiny register machine with an external ALU
module instruction_sequencer
  import nanoprocessor_pkg::*;
#(
  parameter int N      = 4,
  parameter int ADDR_W = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               instr_req,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [N-1:0]       alu_A,
  output logic [N-1:0]       alu_B,
  output logic [1:0]         alu_operation_code,
  input  logic [N-1:0]       alu_result,
  output logic [N-1:0]       display,
  output logic               halted
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                instr_req_q, instr_req_d;
  logic                halted_q, halted_d;
  logic [N-1:0]        alu_a_q, alu_a_d;
  logic [N-1:0]        alu_b_q, alu_b_d;
  alu_code_t           alu_op_q, alu_op_d;

  logic [REG_SEL_W-1:0] ra_sel, rb_sel;
  logic [N-1:0]         rd_a, rd_b;
  logic                 wr_en;
  logic [N-1:0]         wr_data;
  opcode_t              fetch_opc, exec_opc;

  // Operands are read from the incoming word during FETCH so the ALU outputs can be registered
  // on the fetch edge; during EXECUTE the same ports serve JZR from the latched instruction.
  assign ra_sel    = (state_q == ST_FETCH) ? instr_data[RA_LSB +: REG_SEL_W] : ir_q[RA_LSB +: REG_SEL_W];
  assign rb_sel    = (state_q == ST_FETCH) ? instr_data[RB_LSB +: REG_SEL_W] : ir_q[RB_LSB +: REG_SEL_W];
  assign fetch_opc = instr_data[OPC_LSB +: OPC_W];
  assign exec_opc  = ir_q[OPC_LSB +: OPC_W];

  register_bank #(.N(N)) u_register_bank (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_a_sel  (ra_sel),
    .rd_a_data (rd_a),
    .rd_b_sel  (rb_sel),
    .rd_b_data (rd_b),
    .wr_en     (wr_en),
    .wr_sel    (ir_q[RA_LSB +: REG_SEL_W]),
    .wr_data   (wr_data),
    .r7        (display)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    instr_req_d = 1'b0;
    halted_d    = 1'b0;
    alu_a_d     = '0;
    alu_b_d     = '0;
    alu_op_d    = ALU_ADD;
    wr_en       = 1'b0;
    wr_data     = alu_result;

    case (state_q)
      ST_IDLE: begin
        state_d     = ST_FETCH;
        instr_req_d = 1'b1;
      end
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_data;
          state_d = ST_EXECUTE;
          if (is_alu_op(fetch_opc)) begin
            alu_a_d  = rd_a;
            alu_b_d  = rd_b;
            alu_op_d = alu_code_of(fetch_opc);
          end
        end else begin
          instr_req_d = 1'b1;
        end
      end
      ST_EXECUTE: begin
        if (exec_opc == OP_HALT) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d     = ST_FETCH;
          instr_req_d = 1'b1;
          pc_d        = pc_q + ADDR_W'(1);
          case (exec_opc)
            OP_ADD, OP_SUB, OP_AND: wr_en = 1'b1;
            OP_MOVI: begin
              wr_en   = 1'b1;
              wr_data = N'(ir_q[IMM_LSB +: IMM_W]);
            end
            OP_JZR: begin
              if (rd_a == '0) begin
                pc_d = ADDR_W'(ir_q[TGT_LSB +: TGT_W]);
              end
            end
            default: ;
          endcase
        end
      end
      ST_HALT: begin
        halted_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      instr_req_q <= 1'b0;
      halted_q    <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= ALU_ADD;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      instr_req_q <= instr_req_d;
      halted_q    <= halted_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
    end
  end

  assign instr_req          = instr_req_q;
  assign instr_addr         = pc_q;
  assign halted             = halted_q;
  assign alu_A              = alu_a_q;
  assign alu_B              = alu_b_q;
  assign alu_operation_code = alu_op_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - scoreboard bench: ROM and ALU models, directed programs
module tb_instruction_sequencer;

  logic        clock;
  logic        reset_n;
  logic        instr_req;
  logic [2:0]  instr_addr;
  logic        instr_valid;
  logic [11:0] instr_data;
  logic [3:0]  alu_A, alu_B, alu_result, display;
  logic [1:0]  alu_operation_code;
  logic        halted;

  logic [11:0] rom [8];
  logic        rom_valid;
  logic        stray_valid;
  int          wait_cnt;
  int          checks;
  int          failures;
  logic        strict;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
  } exp_t;
  exp_t exp_q[$];

  instruction_sequencer #(.N(4), .ADDR_W(3)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .instr_req          (instr_req),
    .instr_addr         (instr_addr),
    .instr_valid        (instr_valid),
    .instr_data         (instr_data),
    .alu_A              (alu_A),
    .alu_B              (alu_B),
    .alu_operation_code (alu_operation_code),
    .alu_result         (alu_result),
    .display            (display),
    .halted             (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign instr_data  = rom[instr_addr];
  assign instr_valid = rom_valid | stray_valid;

  always_comb begin
    alu_result = 4'h0;
    case (alu_operation_code)
      2'b00: alu_result = alu_A + alu_B;
      2'b01: alu_result = alu_A - alu_B;
      2'b10: alu_result = alu_A & alu_B;
      default: alu_result = 4'h0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] enc_r(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb);
    return {op, ra, rb, 3'b000};
  endfunction

  function automatic logic [11:0] enc_i(input logic [2:0] op, input logic [2:0] ra, input logic [3:0] imm);
    return {op, ra, 2'b00, imm};
  endfunction

  function automatic logic [11:0] enc_j(input logic [2:0] ra, input logic [2:0] tgt);
    return {3'b100, ra, 3'b000, tgt};
  endfunction

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    exp_t e;
    e.a = a;
    e.b = b;
    e.op = op;
    exp_q.push_back(e);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = 12'hA00;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    while (!halted && n < 200) begin
      @(negedge clock);
      n++;
    end
    check(name, halted, 1'b1);
    @(negedge clock);
    @(negedge clock);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // ROM: acknowledges after wait_cnt stall cycles, decided at each falling edge
  initial begin
    rom_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (instr_req && reset_n) begin
        if (wait_cnt == 0) begin
          rom_valid = 1'b1;
        end else begin
          rom_valid = 1'b0;
          wait_cnt--;
        end
      end else begin
        rom_valid = 1'b0;
      end
    end
  end

  // Monitor: a cycle following an accepted fetch is EXECUTE; compare ALU outputs there
  initial begin
    logic pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("exec_alu", {alu_A, alu_B, alu_operation_code}, {e.a, e.b, e.op});
          end else if (strict) begin
            check("unexpected_exec", 1, 0);
          end
        end else begin
          check("alu_idle_zero", {alu_A, alu_B, alu_operation_code}, 10'h0);
        end
        pend = instr_req && instr_valid;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    stray_valid = 1'b0;
    wait_cnt = 0;
    strict = 1'b1;
    clear_rom();

    // ADD with zero-wait ROM: 3 + 5 -> 8, then R1 read back as ALU operand
    rom[0] = enc_i(3'b011, 3'd1, 4'd3);
    rom[1] = enc_i(3'b011, 3'd2, 4'd5);
    rom[2] = enc_r(3'b000, 3'd1, 3'd2);
    rom[3] = enc_r(3'b000, 3'd1, 3'd0);
    rom[4] = 12'hA00;
    push(0, 0, 0); push(0, 0, 0); push(4'd3, 4'd5, 2'b00); push(4'd8, 4'd0, 2'b00); push(0, 0, 0);
    do_reset();
    check("rst_req", instr_req, 0);
    check("rst_halted", halted, 0);
    check("rst_display", display, 0);
    check("rst_addr", instr_addr, 0);
    @(negedge clock);
    check("idle_to_fetch", {instr_req, instr_addr}, {1'b1, 3'd0});
    repeat (6) @(negedge clock);
    check("add_6_cycles", {instr_req, instr_addr}, {1'b1, 3'd3});
    wait_halt("add_halt");
    check("halt_pc", instr_addr, 3'd4);
    stray_valid = 1'b1;
    repeat (3) @(negedge clock);
    check("halt_ignores_valid", {halted, instr_req}, {1'b1, 1'b0});
    stray_valid = 1'b0;

    // SUB wraps: 2 - 3 = F
    clear_rom();
    rom[0] = enc_i(3'b011, 3'd3, 4'd3);
    rom[1] = enc_i(3'b011, 3'd7, 4'd2);
    rom[2] = enc_r(3'b001, 3'd7, 3'd3);
    push(0, 0, 0); push(0, 0, 0); push(4'd2, 4'd3, 2'b01); push(0, 0, 0);
    do_reset();
    wait_halt("sub_halt");
    check("sub_display", display, 4'hF);

    // AND: C & A = 8
    clear_rom();
    rom[0] = enc_i(3'b011, 3'd7, 4'hC);
    rom[1] = enc_i(3'b011, 3'd6, 4'hA);
    rom[2] = enc_r(3'b010, 3'd7, 3'd6);
    push(0, 0, 0); push(0, 0, 0); push(4'hC, 4'hA, 2'b10); push(0, 0, 0);
    do_reset();
    wait_halt("and_halt");
    check("and_display", display, 4'h8);

    // JZR R0 is unconditional: 0 -> 7 -> 5
    clear_rom();
    rom[0] = enc_j(3'd0, 3'd7);
    rom[7] = enc_j(3'd0, 3'd5);
    push(0, 0, 0); push(0, 0, 0); push(0, 0, 0);
    do_reset();
    repeat (3) @(negedge clock);
    check("jzr_r0_to7", instr_addr, 3'd7);
    repeat (2) @(negedge clock);
    check("jzr_r0_to5", instr_addr, 3'd5);
    wait_halt("jzr_halt");

    // JZR R1 not taken at address 7 wraps to 0
    strict = 1'b0;
    clear_rom();
    rom[0] = enc_i(3'b011, 3'd1, 4'd1);
    rom[1] = enc_j(3'd0, 3'd7);
    rom[7] = enc_j(3'd1, 3'd3);
    push(0, 0, 0); push(0, 0, 0); push(0, 0, 0);
    do_reset();
    repeat (5) @(negedge clock);
    check("jzr_at7", instr_addr, 3'd7);
    repeat (2) @(negedge clock);
    check("jzr_wrap", {instr_req, instr_addr}, {1'b1, 3'd0});
    check("jzr_queue", exp_q.size(), 0);

    // Three-cycle ROM stall, then a self-looping JZR
    clear_rom();
    rom[0] = enc_i(3'b011, 3'd7, 4'd9);
    rom[1] = enc_j(3'd0, 3'd1);
    push(0, 0, 0); push(0, 0, 0);
    wait_cnt = 3;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      check("stall_hold", {instr_req, instr_addr, display}, {1'b1, 3'd0, 4'd0});
    end
    @(negedge clock);
    check("stall_exec", instr_req, 0);
    @(negedge clock);
    check("stall_one_exec", {display, instr_addr}, {4'd9, 3'd1});
    repeat (2) @(negedge clock);
    check("self_loop_a", {instr_req, instr_addr}, {1'b1, 3'd1});
    repeat (2) @(negedge clock);
    check("self_loop_b", {instr_req, instr_addr, display}, {1'b1, 3'd1, 4'd9});
    check("stall_queue", exp_q.size(), 0);

    // HALT holds until reset; reset mid-FETCH abandons the handshake
    strict = 1'b1;
    wait_cnt = 0;
    clear_rom();
    rom[0] = enc_i(3'b011, 3'd7, 4'd5);
    push(0, 0, 0); push(0, 0, 0);
    do_reset();
    wait_halt("f_halt");
    repeat (3) @(negedge clock);
    check("f_halt_hold", {halted, instr_req, display}, {1'b1, 1'b0, 4'd5});
    wait_cnt = 10;
    do_reset();
    check("f_rst_display", display, 0);
    @(negedge clock);
    check("f_fetch0", {instr_req, instr_addr}, {1'b1, 3'd0});
    #2;
    reset_n = 1'b0;
    #1;
    check("f_async_drop", {instr_req, halted, display}, {1'b0, 1'b0, 4'd0});
    @(negedge clock);
    wait_cnt = 0;
    push(0, 0, 0); push(0, 0, 0);
    reset_n = 1'b1;
    check("f_idle", {instr_req, instr_addr, display}, {1'b0, 3'd0, 4'd0});
    @(negedge clock);
    check("f_refetch0", {instr_req, instr_addr}, {1'b1, 3'd0});
    wait_halt("f_rerun_halt");
    check("f_rerun_display", display, 4'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning data/operand width.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning program-counter width (8 instructions).
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port instr_req, output, 1, instruction fetch request.
REQ-006 The block SHALL have port instr_addr, output, ADDR_W, fetch address, which equals the PC.
REQ-007 The block SHALL have port instr_valid, input, 1, fetch acknowledge; instr_data is valid while it is high.
REQ-008 The block SHALL have port instr_data, input, 12, instruction word.
REQ-009 The block SHALL have port alu_A, output, N, ALU operand A.
REQ-010 The block SHALL have port alu_B, output, N, ALU operand B.
REQ-011 The block SHALL have port alu_operation_code, output, 2, ALU operation code: 00 add, 01 sub, 10 and.
REQ-012 The block SHALL have port alu_result, input, N, combinational ALU result.
REQ-013 The block SHALL have port display, output, N, current contents of R7.
REQ-014 The block SHALL have port halted, output, 1, high while in HALT.

Function
REQ-015 The instruction format SHALL be: [11:9] opcode, [8:6] ra, [5:3] rb, [3:0] imm, [2:0] target.
REQ-016 The opcodes SHALL be decoded as follows: 000 ADD ra<=ra+rb; 001 SUB ra<=ra-rb; 010 AND ra<=ra&rb; 011 MOVI ra<=imm; 100 JZR, where PC<=target if R[ra]==0; 101 HALT; 110 and 111 NOP.
REQ-017 Register bank: eight N-bit registers; R0 SHALL read 0 and writes to R0 SHALL be discarded.
REQ-018 FSM states SHALL be IDLE, FETCH, EXECUTE and HALT; the state after reset SHALL be IDLE.
REQ-019 IDLE SHALL go to FETCH on the next clock unconditionally, with instr_req=0 in IDLE.
REQ-020 In FETCH, instr_req SHALL be 1 and instr_addr SHALL equal PC; instr_req SHALL be held until a clock edge with instr_valid=1.
REQ-021 On that edge, instr_data SHALL be latched into the instruction register and the state SHALL go to EXECUTE; instr_valid in the same cycle as the request SHALL be accepted (zero wait).
REQ-022 instr_valid outside FETCH SHALL be ignored.
REQ-023 In EXECUTE, alu_A SHALL be R[ra], alu_B SHALL be R[rb], and alu_operation_code SHALL be mapped from the opcode (ADD 00, SUB 01, AND 10).
REQ-024 In EXECUTE, alu_result SHALL be written to ra at the end of the cycle for ADD, SUB and AND.
REQ-025 Outside EXECUTE, and for non-ALU opcodes, alu_A, alu_B and alu_operation_code SHALL be 0.
REQ-026 ALU results SHALL wrap modulo 2^N; no carry or overflow SHALL be tracked.
REQ-027 At the end of EXECUTE, PC SHALL become target for a taken JZR, or PC+1 otherwise, wrapping from 7 to 0; the state SHALL then go to FETCH.
REQ-028 HALT in EXECUTE SHALL go to HALT with PC unchanged; HALT SHALL be left only by reset, and instr_req SHALL be 0 there.
REQ-029 Throughput SHALL be 2 cycles per instruction with zero-wait fetch, plus one cycle per wait cycle.
REQ-030 JZR R0 SHALL act as an unconditional jump.
REQ-031 JZR with target equal to the current PC SHALL loop on itself.
REQ-032 display SHALL follow R7 one cycle after the write edge.

Reset
REQ-033 reset_n low SHALL asynchronously clear PC, all registers, the instruction register and the state (to IDLE), forcing instr_req=0, halted=0, display=0 and alu_*=0.
REQ-034 Reset asserted during FETCH SHALL abandon the handshake: instr_req SHALL drop immediately and no instruction SHALL be latched.
REQ-035 Reset asserted in EXECUTE SHALL suppress the pending register write.

Structure
REQ-036 Package nanoprocessor_pkg SHALL hold the opcode constants, the ALU operation-code constants, the FSM state encoding, and the instruction field positions and widths.
REQ-037 The register file SHALL be a sub-module named register_bank (two read ports, one write port, R0 fixed to zero), and the sequencer FSM SHALL be kept in instruction_sequencer.

Verification
REQ-038 The bench SHALL cover: MOVI R1,3; MOVI R2,5; ADD R1,R2 with zero-wait ROM -> alu_A=3, alu_B=5, op=00 in EXECUTE; R1=8 after; 6 cycles total after IDLE.
REQ-039 The bench SHALL cover: MOVI R7,2; SUB R7,R3 with R3=3 -> display=F (wrap).
REQ-040 The bench SHALL cover: MOVI R7,C; MOVI R6,A; AND R7,R6 -> op=10, display=8.
REQ-041 The bench SHALL cover: JZR R0,5 at address 7 -> next instr_addr=5; JZR R1 with R1=1 at address 7 -> next instr_addr=0 (wrap).
REQ-042 The bench SHALL cover: ROM holding instr_valid low for 3 cycles -> instr_req and instr_addr stable for 4 cycles; one instruction executes.
REQ-043 The bench SHALL cover: HALT then reset_n pulse mid-FETCH -> halted=1 and instr_req=0 until reset; after reset, IDLE then FETCH at address 0 with all registers 0.
